// File: rtl/vending_machine_param.sv
// vending_machine_param
//   Coin-operated vending controller. It accepts nickels, dimes and quarters,
//   dispenses one item when the credit reaches PRICE, and pays back any change
//   dimes-first, one coin per cycle. Cancel refunds the current credit.
//
// Parameters
//   PRICE    item price in nickels (legal range 1 .. 2^CREDIT_W-6)
//   CREDIT_W credit register width in nickels
//   COUNT_W  vend counter width (the counter wraps modulo 2^COUNT_W)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   N, D, Q      nickel / dime / quarter inserted this cycle
//   Cancel       refund request
//   Dispense     one-cycle item release pulse
//   ReturnNickel one nickel released this cycle
//   ReturnDime   one dime released this cycle
//   Busy         coin gate closed (state is not ACCUM)
//   CoinErr      one-cycle pulse after an illegal multi-coin input
//   Credit       current credit in nickels
//   VendCount    items dispensed since reset
module vending_machine_param #(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 4,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                Cancel,
  output logic                Dispense,
  output logic                ReturnNickel,
  output logic                ReturnDime,
  output logic                Busy,
  output logic                CoinErr,
  output logic [CREDIT_W-1:0] Credit,
  output logic [COUNT_W-1:0]  VendCount
);

  typedef enum logic [1:0] {
    ACCUM    = 2'b00,
    DISPENSE = 2'b01,
    CHANGE   = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);

  state_t               currentState, nextState;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [COUNT_W-1:0]   vend_q, vend_d;
  logic                 coinerr_q, coinerr_d;
  logic [CREDIT_W-1:0]  sum;
  logic                 multi_coin;

  // Value in nickels of a single legal coin; zero for no coin or several coins.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic n, input logic d,
                                                     input logic q);
    logic [CREDIT_W-1:0] v;
    v = '0;
    case ({n, d, q})
      3'b100:  v = CREDIT_W'(1);
      3'b010:  v = CREDIT_W'(2);
      3'b001:  v = CREDIT_W'(5);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic two_or_more(input logic n, input logic d, input logic q);
    return (n & d) | (n & q) | (d & q);
  endfunction

  // Credit never exceeds PRICE+4, so this sum cannot overflow for legal PRICE.
  assign sum        = credit_q + coin_value(N, D, Q);
  assign multi_coin = two_or_more(N, D, Q);

  always_comb begin
    nextState = currentState;
    credit_d  = credit_q;
    vend_d    = vend_q;
    coinerr_d = 1'b0;
    case (currentState)
      ACCUM: begin
        coinerr_d = multi_coin;
        // Cancel outranks a purchase, so a coin arriving with Cancel is refunded.
        if (Cancel && (sum != '0)) begin
          nextState = CHANGE;
          credit_d  = sum;
        end else if (sum >= PRICE_C) begin
          nextState = DISPENSE;
          credit_d  = sum - PRICE_C;
        end else begin
          credit_d  = sum;
        end
      end
      DISPENSE: begin
        vend_d    = vend_q + COUNT_W'(1);
        nextState = (credit_q != '0) ? CHANGE : ACCUM;
      end
      CHANGE: begin
        // Dimes first; the last odd nickel finishes the payout.
        credit_d  = (credit_q >= TWO_C) ? (credit_q - TWO_C) : '0;
        nextState = (credit_d == '0) ? ACCUM : CHANGE;
      end
      default: nextState = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      currentState <= ACCUM;
      credit_q     <= '0;
      vend_q       <= '0;
      coinerr_q    <= 1'b0;
    end else begin
      currentState <= nextState;
      credit_q     <= credit_d;
      vend_q       <= vend_d;
      coinerr_q    <= coinerr_d;
    end
  end

  // Moore outputs: decoded from the state register and the credit only.
  assign Dispense     = (currentState == DISPENSE);
  assign ReturnDime   = (currentState == CHANGE) && (credit_q >= TWO_C);
  assign ReturnNickel = (currentState == CHANGE) && (credit_q == ONE_C);
  assign Busy         = (currentState != ACCUM);
  assign CoinErr      = coinerr_q;
  assign Credit       = credit_q;
  assign VendCount    = vend_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: a transaction-level model (credit plus a
// queue of pending payout events) is compared with the DUT on every falling
// edge; directed scenarios add literal expectations, then random coins,
// cancels and asynchronous resets follow. A second instance with COUNT_W=2
// shares the stimulus to exercise counter wrap.
module tb_vending_machine_param;
  localparam int PRICE   = 5;
  localparam int EV_DISP = 0;
  localparam int EV_DIME = 1;
  localparam int EV_NICK = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic N = 1'b0, D = 1'b0, Q = 1'b0, Cancel = 1'b0;
  logic Dispense, ReturnNickel, ReturnDime, Busy, CoinErr;
  logic [3:0]  Credit;
  logic [15:0] VendCount;
  logic s_Dispense, s_ReturnNickel, s_ReturnDime, s_Busy, s_CoinErr;
  logic [3:0] s_Credit;
  logic [1:0] s_VendCount;

  vending_machine_param #(.PRICE(PRICE), .CREDIT_W(4), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q), .Cancel(Cancel),
    .Dispense(Dispense), .ReturnNickel(ReturnNickel), .ReturnDime(ReturnDime),
    .Busy(Busy), .CoinErr(CoinErr), .Credit(Credit), .VendCount(VendCount));

  vending_machine_param #(.PRICE(PRICE), .CREDIT_W(4), .COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q), .Cancel(Cancel),
    .Dispense(s_Dispense), .ReturnNickel(s_ReturnNickel), .ReturnDime(s_ReturnDime),
    .Busy(s_Busy), .CoinErr(s_CoinErr), .Credit(s_Credit), .VendCount(s_VendCount));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: displayed credit, items sold, error flag, pending payout events.
  int m_credit = 0;
  int m_vend   = 0;
  bit m_err    = 1'b0;
  int evq[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push_change(input int amt);
    for (int i = 0; i < amt / 2; i++) evq.push_back(EV_DIME);
    if (amt % 2 != 0) evq.push_back(EV_NICK);
  endfunction

  function automatic void model_reset();
    m_credit = 0;
    m_vend   = 0;
    m_err    = 1'b0;
    evq.delete();
  endfunction

  function automatic void model_step(input bit n, input bit d, input bit q, input bit c);
    int nc, val, sum, ev;
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      m_err = 1'b0;
      if (ev == EV_DISP)      m_vend++;
      else if (ev == EV_DIME) m_credit -= 2;
      else                    m_credit -= 1;
    end else begin
      nc    = int'(n) + int'(d) + int'(q);
      m_err = (nc >= 2);
      val   = (nc != 1) ? 0 : (n ? 1 : (d ? 2 : 5));
      sum   = m_credit + val;
      if (c && sum > 0) begin
        m_credit = sum;
        push_change(sum);
      end else if (sum >= PRICE) begin
        m_credit = sum - PRICE;
        evq.push_back(EV_DISP);
        push_change(m_credit);
      end else begin
        m_credit = sum;
      end
    end
  endfunction

  // One clock of stimulus; the model advances on the same rising edge.
  task automatic step(input bit n, input bit d, input bit q, input bit c);
    N = n; D = d; Q = q; Cancel = c;
    @(posedge clk);
    model_step(n, d, q, c);
    #1;
    N = 1'b0; D = 1'b0; Q = 1'b0; Cancel = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_reset();
    #1;
    chk({tag, " rst Credit"}, Credit, 0);
    chk({tag, " rst Busy"}, Busy, 0);
    chk({tag, " rst Dispense"}, Dispense, 0);
    chk({tag, " rst ReturnDime"}, ReturnDime, 0);
    chk({tag, " rst ReturnNickel"}, ReturnNickel, 0);
    chk({tag, " rst CoinErr"}, CoinErr, 0);
    chk({tag, " rst VendCount"}, VendCount, 0);
    chk({tag, " rst state"}, int'(dut.currentState), 0);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  always @(negedge clk) begin
    int f;
    if (chk_en) begin
      f = (evq.size() > 0) ? evq[0] : -1;
      chk("Dispense", Dispense, (f == EV_DISP) ? 1 : 0);
      chk("ReturnDime", ReturnDime, (f == EV_DIME) ? 1 : 0);
      chk("ReturnNickel", ReturnNickel, (f == EV_NICK) ? 1 : 0);
      chk("Busy", Busy, (evq.size() > 0) ? 1 : 0);
      chk("CoinErr", CoinErr, int'(m_err));
      chk("Credit", Credit, m_credit);
      chk("VendCount", VendCount, m_vend % 65536);
      chk("VendCount2", s_VendCount, m_vend % 4);
      chk("state", int'(dut.currentState), (f < 0) ? 0 : ((f == EV_DISP) ? 1 : 2));
      chk("Credit bound", (int'(Credit) <= PRICE + 4) ? 1 : 0, 1);
    end
  end

  initial begin
    int r, cn;
    bit c;
    #1 reset = 1'b0;
    #4;
    chk("init Credit", Credit, 0);
    chk("init Busy", Busy, 0);
    chk("init VendCount", VendCount, 0);
    chk("init CoinErr", CoinErr, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    // Quarter on zero credit: vend with no change.
    step(0, 0, 1, 0);
    chk("q Dispense", Dispense, 1);
    chk("q Credit", Credit, 0);
    step(0, 0, 0, 0);
    chk("q back", Busy, 0);
    chk("q VendCount", VendCount, 1);

    // Three dimes: vend, one nickel back.
    step(0, 1, 0, 0); chk("ddd c2", Credit, 2);
    step(0, 1, 0, 0); chk("ddd c4", Credit, 4);
    step(0, 1, 0, 0); chk("ddd disp", Dispense, 1); chk("ddd c1", Credit, 1);
    step(0, 0, 0, 0); chk("ddd nickel", ReturnNickel, 1); chk("ddd nodime", ReturnDime, 0);
    step(0, 0, 0, 0); chk("ddd idle", Busy, 0); chk("ddd c0", Credit, 0);

    // Two dimes then quarter: vend, two dimes back.
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 1, 0); chk("ddq disp", Dispense, 1); chk("ddq c4", Credit, 4);
    step(0, 0, 0, 0); chk("ddq dime1", ReturnDime, 1);
    step(0, 0, 0, 0); chk("ddq dime2", ReturnDime, 1); chk("ddq c2", Credit, 2);
    step(0, 0, 0, 0); chk("ddq idle", Busy, 0); chk("ddq vend", VendCount, 3);

    // Nickel, dime, cancel: refund dime then nickel, no vend.
    step(1, 0, 0, 0); step(0, 1, 0, 0); chk("cancel c3", Credit, 3);
    step(0, 0, 0, 1); chk("cancel dime", ReturnDime, 1); chk("cancel nodisp", Dispense, 0);
    step(0, 0, 0, 0); chk("cancel nickel", ReturnNickel, 1);
    step(0, 0, 0, 0); chk("cancel idle", Busy, 0); chk("cancel vend", VendCount, 3);

    // Two coins at once, then a quarter ignored while paying change.
    step(1, 0, 1, 0); chk("multi err", CoinErr, 1); chk("multi credit", Credit, 0);
    step(0, 0, 0, 0); chk("multi err off", CoinErr, 0);
    step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 1);
    step(0, 0, 1, 0); chk("busyq credit", Credit, 1); chk("busyq err", CoinErr, 0);
    step(0, 0, 0, 0); chk("busyq idle", Busy, 0); chk("busyq c0", Credit, 0);
    step(0, 0, 0, 0); chk("busyq noerr", CoinErr, 0);

    // Asynchronous reset in the middle of a change payout.
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);
    chk("mid change", ReturnDime, 1);
    do_reset("midchg");
    step(0, 0, 0, 0); chk("after rst", Busy, 0); chk("after rst c", Credit, 0);

    // Five vends wrap the 2-bit counter to 1.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    chk("wrap small", s_VendCount, 1);
    chk("wrap wide", VendCount, 5);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset("rand");
      end else begin
        cn = $urandom_range(0, 9);
        c  = ($urandom_range(0, 9) == 0);
        case (cn)
          4, 5:    step(1, 0, 0, c);
          6:       step(0, 1, 0, c);
          7:       step(0, 0, 1, c);
          8:       step(1, $urandom_range(0, 1), 1, c);
          9:       step(1, 1, 1, c);
          default: step(0, 0, 0, c);
        endcase
      end
    end

    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vending_machine_param.md
VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL provide parameter PRICE, default 5, meaning item price in nickels (5 = 25c); legal range 1..(2^CREDIT_W - 6).
REQ-002 SHALL provide parameter CREDIT_W, default 4, meaning credit register width in nickels.
REQ-003 SHALL provide parameter COUNT_W, default 16, meaning width of the vend counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 N  input  1  nickel inserted this cycle (value 1).
REQ-007 D  input  1  dime inserted this cycle (value 2).
REQ-008 Q  input  1  quarter inserted this cycle (value 5).
REQ-009 Cancel  input  1  request refund of current credit.
REQ-010 Dispense  output  1  one-cycle item release pulse.
REQ-011 ReturnNickel  output  1  one nickel released this cycle.
REQ-012 ReturnDime  output  1  one dime released this cycle.
REQ-013 Busy  output  1  high when state is not ACCUM; coin gate closed.
REQ-014 CoinErr  output  1  one-cycle pulse, illegal multi-coin input.
REQ-015 Credit  output  CREDIT_W  current credit in nickels.
REQ-016 VendCount  output  COUNT_W  total items dispensed since reset.

Function
REQ-017 The state register currentState and combinational nextState SHALL be 2 bits, hierarchically visible, encoding ACCUM=00, DISPENSE=01, CHANGE=10; 11 SHALL recover to ACCUM next cycle.
REQ-018 Dispense, ReturnNickel, ReturnDime and Busy SHALL be Moore outputs decoded from currentState and Credit only.
REQ-019 In ACCUM, exactly one of N/D/Q high SHALL be a legal coin; value added to Credit on that edge.
REQ-020 In ACCUM, two or more of N/D/Q high SHALL leave Credit unchanged and raise CoinErr on the following cycle for one cycle.
REQ-021 Coin inputs while Busy=1 SHALL be ignored (no credit, no CoinErr).
REQ-022 In ACCUM, legal coin with Credit+value >= PRICE and Cancel=0 SHALL move to DISPENSE with Credit <= Credit+value-PRICE.
REQ-023 In DISPENSE: Dispense=1 for exactly one cycle; VendCount increments by 1 (modulo 2^COUNT_W, wraps to 0); next state CHANGE if Credit != 0, else ACCUM.
REQ-024 In CHANGE: ReturnDime=1 if Credit >= 2, else ReturnNickel=1; Credit decreases by 2 or 1 at the edge; never both outputs high.
REQ-025 CHANGE SHALL exit to ACCUM on the edge where Credit becomes 0; change paid dimes-first, one coin per cycle.
REQ-026 In ACCUM, Cancel=1 with Credit+coin value > 0 SHALL move to CHANGE with Credit <= Credit+coin value; no Dispense (Cancel outranks purchase).
REQ-027 Cancel with zero credit and no coin, or Cancel while Busy, SHALL be ignored.
REQ-028 Credit SHALL never exceed PRICE+4; arithmetic SHALL be unsigned CREDIT_W bits with no overflow for legal PRICE.

Reset
REQ-029 reset=0 SHALL immediately force currentState=ACCUM, Credit=0, VendCount=0, CoinErr=0, and all Moore outputs low, regardless of clk.
REQ-030 Reset asserted mid-DISPENSE or mid-CHANGE SHALL abandon the transaction (owed change lost); first edge after release starts in ACCUM.

Verification (PRICE=5, CREDIT_W=4)
REQ-031 Q in ACCUM with Credit=0 -> next cycle DISPENSE, Dispense=1, Credit=0; following cycle ACCUM, VendCount=1.
REQ-032 D,D,D on consecutive cycles -> Credit 2,4, then DISPENSE Credit=1, then CHANGE ReturnNickel=1, then ACCUM Credit=0.
REQ-033 D,D then Q -> DISPENSE Credit=4, then ReturnDime two consecutive cycles (Credit 2, 0), then ACCUM.
REQ-034 N,D (Credit=3) then Cancel -> CHANGE: ReturnDime then ReturnNickel, no Dispense, VendCount unchanged.
REQ-035 N and Q together in ACCUM -> Credit unchanged, CoinErr=1 one cycle; Q during CHANGE -> ignored.
REQ-036 reset=0 asynchronously mid-CHANGE -> outputs and Credit 0 before next edge; with COUNT_W=2, five vends -> VendCount wraps to 1.
